// File: rtl/stack_backing_if.sv
// Memory-side bus of stack_backing: one outstanding word request, completed on req && ack.
interface stack_backing_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  ack;
    logic [WIDTH-1:0]      rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/stack_backing.sv
// Bottom-end extension of the register stack: hold register plus spill/fill to external memory.
// Optional sticky overflow/underflow flags are built when STACK_BACKING_FLAGS_EN is defined.
module stack_backing #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      bottom,
    output logic [WIDTH-1:0]      below,
    output logic                  stall,
    stack_backing_if.master       mem,
    output logic [ADDR_WIDTH:0]   mem_count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPILL = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic [CW-1:0]         reg_count_q,  reg_count_d;
    logic [WIDTH-1:0]      hold_q,       hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [ADDR_WIDTH:0]   sp_q,         sp_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q,  mem_wdata_d;
    logic                  mem_we_q,     mem_we_d;

    logic idle;
    logic apush;
    logic apop;
    logic regs_full;
    logic mem_full;

    assign idle      = (state_q == ST_IDLE);
    assign apush     = push & ~pop & idle;
    assign apop      = pop & ~push & idle;
    assign regs_full = (reg_count_q == DEPTH_C);
    // sp never exceeds 2**ADDR_WIDTH, so its MSB alone marks a full memory
    assign mem_full  = sp_q[ADDR_WIDTH];

    always_comb begin
        state_d      = state_q;
        reg_count_d  = reg_count_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sp_d         = sp_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;

        case (state_q)
            ST_IDLE: begin
                if (apush) begin
                    if (!regs_full) begin
                        reg_count_d = reg_count_q + 1'b1;
                    end else if (!hold_valid_q) begin
                        hold_d       = bottom;
                        hold_valid_d = 1'b1;
                    end else if (!mem_full) begin
                        mem_wdata_d = hold_q;
                        mem_addr_d  = sp_q[ADDR_WIDTH-1:0];
                        mem_we_d    = 1'b1;
                        hold_d      = bottom;
                        state_d     = ST_SPILL;
                    end else begin
                        // memory full: the oldest held element is lost
                        hold_d = bottom;
                    end
                end else if (apop) begin
                    if (hold_valid_q) begin
                        hold_valid_d = 1'b0;
                        if (sp_q != '0) begin
                            mem_addr_d = sp_q[ADDR_WIDTH-1:0] - 1'b1;
                            mem_we_d   = 1'b0;
                            state_d    = ST_FILL;
                        end
                    end else if (reg_count_q != '0) begin
                        reg_count_d = reg_count_q - 1'b1;
                    end
                end
            end
            ST_SPILL: begin
                if (mem.ack) begin
                    sp_d    = sp_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (mem.ack) begin
                    hold_d       = mem.rdata;
                    hold_valid_d = 1'b1;
                    sp_d         = sp_q - 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            reg_count_q  <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sp_q         <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            reg_count_q  <= reg_count_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sp_q         <= sp_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign below     = hold_valid_q ? hold_q : '0;
    assign stall     = ~idle;
    assign mem_count = sp_q;
    assign mem.req   = ~idle;
    assign mem.we    = mem_we_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;

`ifdef STACK_BACKING_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (apush & regs_full & hold_valid_q & mem_full);
        underflow_d = underflow_q | (apop & ~hold_valid_q & (reg_count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_stack_backing.sv
// Directed bench for stack_backing with DEPTH=2, ADDR_WIDTH=2 and a 3-cycle-ack memory model.
module tb_stack_backing;
    localparam int unsigned W  = 32;
    localparam int unsigned D  = 2;
    localparam int unsigned AW = 2;

`ifdef STACK_BACKING_FLAGS_EN
    localparam logic FLAG_EXP = 1'b1;
`else
    localparam logic FLAG_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [W-1:0]  bottom;
    logic [W-1:0]  below;
    logic          stall;
    logic [AW:0]   mem_count;
    logic          overflow;
    logic          underflow;

    logic          ack_en;
    logic [1:0]    wait_cnt;
    logic [W-1:0]  mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;
    int n;

    stack_backing_if #(.WIDTH(W), .ADDR_WIDTH(AW)) mb ();

    stack_backing #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .bottom    (bottom),
        .below     (below),
        .stall     (stall),
        .mem       (mb.master),
        .mem_count (mem_count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // ack in the third consecutive request cycle
    assign mb.ack   = ack_en && mb.req && (wait_cnt == 2'd2);
    assign mb.rdata = mem[mb.addr];

    always @(posedge clk) begin
        if (!mb.req || mb.ack) wait_cnt <= 2'd0;
        else                   wait_cnt <= wait_cnt + 2'd1;
        if (mb.req && mb.ack && mb.we) mem[mb.addr] <= mb.wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic pu, input logic po, input logic [W-1:0] b);
        push   = pu;
        pop    = po;
        bottom = b;
        tick();
        push   = 1'b0;
        pop    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (stall && cycles < 20) begin
            cycles++;
            tick();
        end
        check({tag, "_timeout"}, stall, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        wait_cnt = 2'd0;
        ack_en   = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        bottom   = '0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_below", below, 0);
        check("rst_stall", stall, 0);
        check("rst_count", mem_count, 0);
        check("rst_req",   mb.req, 0);

        // push 1,2,3: two registers fill, then element 1 falls into hold
        op(1, 0, 0);
        op(1, 0, 0);
        check("p2_stall", stall, 0);
        op(1, 0, 1);
        check("p3_stall", stall, 0);
        check("p3_req",   mb.req, 0);
        check("p3_below", below, 1);
        check("p3_regs",  dut.reg_count_q, 2);

        // push 4: spill held 1 to address 0
        op(1, 0, 2);
        check("sp_req",   mb.req, 1);
        check("sp_we",    mb.we, 1);
        check("sp_addr",  mb.addr, 0);
        check("sp_wdata", mb.wdata, 1);
        check("sp_stall", stall, 1);
        wait_idle("sp", n);
        check("sp_cycles", n, 3);
        check("sp_count",  mem_count, 1);
        check("sp_below",  below, 2);
        check("sp_mem0",   mem[0], 1);

        // pop consumes hold=2, then refill from address 0
        pop = 1'b1;
        #1;
        check("pop1_below", below, 2);
        tick();
        pop = 1'b0;
        check("fl_req",  mb.req, 1);
        check("fl_we",   mb.we, 0);
        check("fl_addr", mb.addr, 0);
        wait_idle("fl", n);
        check("fl_count", mem_count, 0);
        check("fl_below", below, 1);

        pop = 1'b1;
        #1;
        check("pop2_below", below, 1);
        tick();
        pop = 1'b0;
        check("pop2_after", below, 0);
        check("pop2_req",   mb.req, 0);
        op(0, 1, 0);
        check("pop3_regs", dut.reg_count_q, 1);

        // refill to full with one word in memory, then push&pop together
        op(1, 0, 0);
        op(1, 0, 20);
        op(1, 0, 21);
        wait_idle("sp2", n);
        check("sp2_count", mem_count, 1);
        check("sp2_mem0",  mem[0], 20);
        op(1, 1, 99);
        check("pp_req",   mb.req, 0);
        check("pp_stall", stall, 0);
        check("pp_count", mem_count, 1);
        check("pp_below", below, 21);
        check("pp_regs",  dut.reg_count_q, 2);

        // underflow from empty
        do_reset();
        check("rst2_count", mem_count, 0);
        check("rst2_below", below, 0);
        op(0, 1, 0);
        check("uf_flag",  underflow, FLAG_EXP);
        check("uf_count", mem_count, 0);
        check("uf_regs",  dut.reg_count_q, 0);
        check("uf_stall", stall, 0);

        // seven pushes fill regs + hold + memory; bottom lags the pushed value by two
        for (int k = 1; k <= 7; k++) begin
            op(1, 0, (k >= 3) ? W'(k - 2) : '0);
            wait_idle("fill7", n);
        end
        check("f7_count", mem_count, 4);
        check("f7_below", below, 5);
        check("f7_ovf",   overflow, 0);
        check("f7_mem",   {mem[0][7:0], mem[1][7:0], mem[2][7:0], mem[3][7:0]}, 32'h01020304);

        op(1, 0, 6);
        check("ov_req",   mb.req, 0);
        check("ov_stall", stall, 0);
        check("ov_flag",  overflow, FLAG_EXP);
        check("ov_count", mem_count, 4);
        check("ov_below", below, 6);
        check("ov_uf",    underflow, FLAG_EXP);

        // pop from a full memory reads the top word at address 3
        pop = 1'b1;
        #1;
        check("pf_below", below, 6);
        tick();
        pop = 1'b0;
        check("pf_addr", mb.addr, 3);
        check("pf_we",   mb.we, 0);
        wait_idle("pf", n);
        check("pf_count",  mem_count, 3);
        check("pf_below2", below, 4);

        // reset during a spill whose ack never comes
        ack_en = 1'b0;
        op(1, 0, 50);
        check("rs_req",   mb.req, 1);
        check("rs_addr",  mb.addr, 3);
        check("rs_wdata", mb.wdata, 4);
        tick();
        tick();
        check("rs_hold",  mb.req, 1);
        do_reset();
        check("rs2_req",   mb.req, 0);
        check("rs2_stall", stall, 0);
        check("rs2_count", mem_count, 0);
        check("rs2_below", below, 0);
        check("rs2_addr",  mb.addr, 0);
        check("rs2_wdata", mb.wdata, 0);
        check("rs2_we",    mb.we, 0);
        check("rs2_ovf",   overflow, 0);
        check("rs2_uf",    underflow, 0);
        ack_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stack_backing.md
# stack_backing

Bottom-end companion to the register `stack`: catches the element that falls out of the bottom register on a push when the stack is full, spills older elements to an external memory, and refills the stack's bottom `below` input on a pop. It gives the core a logically deep stack: `DEPTH` registers, plus a one-entry hold register, plus a memory region of `2**ADDR_WIDTH` words. It also drives a `stall` to the issue logic while a memory transfer is in flight.

## Interface
- `WIDTH`, 32, element width.
- `DEPTH`, 2, depth of the attached register stack (≥2).
- `ADDR_WIDTH`, 10, backing memory address width; capacity `2**ADDR_WIDTH` words.

- `clk` input 1: clock; single clock domain.
- `reset` input 1: reset, synchronous and active-high.
- `push` input 1: same push strobe as the register stack.
- `pop` input 1: same pop strobe as the register stack.
- `bottom` input WIDTH: current bottom register of the stack, `data[DEPTH-1]`.
- `below` output WIDTH: wired to the bottom element's `below` input. Equals `hold` when `hold_valid`, else 0.
- `stall` output 1: high while state ≠ IDLE. While it is high, upstream must hold off, and `push`/`pop` are ignored.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write (spill), 0 = read (fill).
- `mem_addr` output ADDR_WIDTH: word address.
- `mem_wdata` output WIDTH: spill data.
- `mem_ack` input 1: request completes on the edge where `mem_req && mem_ack`.
- `mem_rdata` input WIDTH: fill data, valid in the ack cycle.
- `mem_count` output ADDR_WIDTH+1: words held in memory.
- `overflow` output 1: sticky; see Configuration.
- `underflow` output 1: sticky; see Configuration.

## Operation
- Internal state:
  - `reg_count`: 0..DEPTH.
  - `hold` and `hold_valid`.
  - `sp`: equals `mem_count`.
  - FSM with states IDLE, SPILL, FILL.
- Push/pop decode:
  - `apush = push & !pop`.
  - `apop = pop & !push`.
  - `push & pop` replaces the top: no count change and no memory activity.
- Invariants in IDLE:
  - `hold_valid` implies `reg_count == DEPTH`.
  - `mem_count > 0` implies `hold_valid`.
- IDLE, `apush`:
  - If `reg_count < DEPTH`: `reg_count++`.
  - Else if `!hold_valid`: `hold <= bottom`, `hold_valid <= 1`.
  - Else if `mem_count < 2**ADDR_WIDTH`: `mem_wdata <= hold`, `mem_addr <= sp`, `hold <= bottom`, go to SPILL.
  - Else (memory full): `hold <= bottom`, old `hold` is dropped, `overflow <= 1`, stay in IDLE.
- IDLE, `apop`:
  - If `hold_valid`: the stack consumes `below = hold` this cycle and `hold_valid <= 0`. If `mem_count > 0`, set `mem_addr <= sp-1` and go to FILL.
  - Else if `reg_count > 0`: `reg_count--`.
  - Else: `underflow <= 1`; counts stay 0.
- SPILL:
  - `mem_req = 1`, `mem_we = 1`.
  - On ack: `sp++`, go to IDLE.
- FILL:
  - `mem_req = 1`, `mem_we = 0`.
  - On ack: `hold <= mem_rdata`, `hold_valid <= 1`, `sp--`, go to IDLE.
- `mem_addr`, `mem_we` and `mem_wdata` are registered and stable for the whole time `mem_req` is high.
- Reset, including mid-SPILL/FILL:
  - Next cycle: state IDLE, `mem_req = 0`, `stall = 0`, `reg_count = sp = 0`, `hold_valid = 0`, `hold = 0`, `below = 0`, `mem_addr = 0`, `mem_wdata = 0`, `mem_we = 0`, flags 0.
  - An in-flight transaction is abandoned; memory contents are logically discarded.

## Timing
- A triggering push/pop is accepted in its own cycle.
- SPILL/FILL is entered on the next edge, so `mem_req` and `stall` rise one cycle after the trigger.
- Minimum SPILL/FILL occupancy is one cycle (ack in the first request cycle). `stall` falls the cycle after the ack edge.
- `mem_ack` is ignored when `mem_req = 0`.
- `below` is combinational from registered `hold`/`hold_valid`. It is valid in the same cycle as the pop that consumes it.
- After a FILL completes, the refilled `hold` is available to a pop in the first cycle back in IDLE.
- Throughput: one push/pop per cycle while no memory transfer is needed.

## Configuration
- `STACK_BACKING_FLAGS_EN`:
  - Defined: `overflow`/`underflow` are sticky registers, cleared only by `reset`.
  - Undefined: both outputs are tied to 0 and their registers are removed. Overflow and underflow handling of data and counts is unchanged.

## Test plan
All scenarios use DEPTH=2, ADDR_WIDTH=2, and a memory model with 3-cycle ack.

- Push 1, 2, 3 from reset -> `reg_count = 2`, `hold = 1`, `below = 1`, no `mem_req`, `stall` stays 0.
- Then push 4 -> next cycle `mem_req = 1`, `mem_we = 1`, `mem_addr = 0`, `mem_wdata = 1`. `stall` high until the cycle after ack. Then `mem_count = 1`, `below = 2`.
- Then pop -> `below = 2` in the pop cycle. FILL read at `mem_addr = 0`, `mem_rdata = 1` -> `hold = 1`, `mem_count = 0`. Pop twice more -> `below = 1` is consumed, then `reg_count` decrements to 1.
- Simultaneous push and pop while full with `mem_count = 1` -> no `mem_req`, no `stall`, all counts unchanged.
- Pop from empty -> `underflow = 1`, counts 0. Push 7 elements (fills 2 regs + hold + 4 mem) and then an 8th -> `overflow = 1`, no `mem_req` for the 8th, `mem_count = 4`. With the macro undefined, both flags stay 0.
- Assert `reset` during SPILL with `mem_ack` held low -> next cycle `mem_req = 0`, `stall = 0`, `mem_count = 0`, `below = 0`.
